// File: rtl/glitch_sequencer.sv
// Glitch-timing sequencer: waits for a target trigger edge, delays, then emits a pulse burst on
// fault_out, stepping the delay between attempts to sweep it unattended.
module glitch_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             trigger_in,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_step,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [7:0]       cfg_pulses,
    input  logic [15:0]      cfg_attempts,
    input  logic [CNT_W-1:0] cfg_holdoff,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             fault_out,
    output logic             busy,
    output logic             armed,
    output logic             attempt_done,
    output logic             missed,
    output logic [15:0]      attempt_idx,
    output logic [CNT_W-1:0] cur_delay,
    output logic             sweep_done
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StDelay,
        StPulse,
        StGap,
        StHoldoff
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, trig_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pulses_left_q, pulses_left_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] width_m1_q, width_m1_d;
    logic [CNT_W-1:0] gap_m1_q, gap_m1_d;
    logic [7:0]       pulses_m1_q, pulses_m1_d;
    logic [15:0]      attempts_m1_q, attempts_m1_d;
    logic [CNT_W-1:0] holdoff_q, holdoff_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic             fault_q, fault_d;
    logic             attempt_done_q, attempt_done_d;
    logic             missed_q, missed_d;
    logic             sweep_done_q, sweep_done_d;
    logic [15:0]      attempt_idx_q, attempt_idx_d;
    logic [CNT_W-1:0] cur_delay_q, cur_delay_d;
    logic             trig_rise;

    assign trig_rise = sync2_q & ~trig_prev_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pulses_left_d  = pulses_left_q;
        step_d         = step_q;
        width_m1_d     = width_m1_q;
        gap_m1_d       = gap_m1_q;
        pulses_m1_d    = pulses_m1_q;
        attempts_m1_d  = attempts_m1_q;
        holdoff_d      = holdoff_q;
        timeout_d      = timeout_q;
        attempt_done_d = 1'b0;
        missed_d       = missed_q;
        sweep_done_d   = 1'b0;
        attempt_idx_d  = attempt_idx_q;
        cur_delay_d    = cur_delay_q;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Lengths are stored minus one so zero-means-one falls out naturally.
                        step_d        = cfg_step;
                        width_m1_d    = (cfg_width == '0) ? '0 : cfg_width - CntOne;
                        gap_m1_d      = (cfg_gap == '0) ? '0 : cfg_gap - CntOne;
                        pulses_m1_d   = (cfg_pulses == 8'd0) ? 8'd0 : cfg_pulses - 8'd1;
                        attempts_m1_d = (cfg_attempts == 16'd0) ? 16'd0 : cfg_attempts - 16'd1;
                        holdoff_d     = cfg_holdoff;
                        timeout_d     = cfg_timeout;
                        cur_delay_d   = cfg_delay;
                        attempt_idx_d = 16'd0;
                        cnt_d         = cfg_timeout - CntOne;
                        state_d       = StArm;
                    end
                end
                StArm: begin
                    if (trig_rise) begin
                        pulses_left_d = pulses_m1_q;
                        if (cur_delay_q == '0) begin
                            state_d = StPulse;
                            cnt_d   = width_m1_q;
                        end else begin
                            state_d = StDelay;
                            cnt_d   = cur_delay_q - CntOne;
                        end
                    end else if (timeout_q != '0 && cnt_q == '0) begin
                        state_d        = StHoldoff;
                        cnt_d          = holdoff_q;
                        attempt_done_d = 1'b1;
                        missed_d       = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StDelay: begin
                    if (cnt_q == '0) begin
                        state_d = StPulse;
                        cnt_d   = width_m1_q;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StPulse: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end else if (pulses_left_q == 8'd0) begin
                        state_d        = StHoldoff;
                        cnt_d          = holdoff_q;
                        attempt_done_d = 1'b1;
                        missed_d       = 1'b0;
                    end else begin
                        pulses_left_d = pulses_left_q - 8'd1;
                        state_d       = StGap;
                        cnt_d         = gap_m1_q;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_d = StPulse;
                        cnt_d   = width_m1_q;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StHoldoff: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end else if (attempt_idx_q == attempts_m1_q) begin
                        state_d      = StIdle;
                        sweep_done_d = 1'b1;
                    end else begin
                        attempt_idx_d = attempt_idx_q + 16'd1;
                        cur_delay_d   = cur_delay_q + step_q;
                        cnt_d         = timeout_q - CntOne;
                        state_d       = StArm;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        fault_d = (state_d == StPulse);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            trig_prev_q    <= 1'b0;
            cnt_q          <= '0;
            pulses_left_q  <= 8'd0;
            step_q         <= '0;
            width_m1_q     <= '0;
            gap_m1_q       <= '0;
            pulses_m1_q    <= 8'd0;
            attempts_m1_q  <= 16'd0;
            holdoff_q      <= '0;
            timeout_q      <= '0;
            fault_q        <= 1'b0;
            attempt_done_q <= 1'b0;
            missed_q       <= 1'b0;
            sweep_done_q   <= 1'b0;
            attempt_idx_q  <= 16'd0;
            cur_delay_q    <= '0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= trigger_in;
            sync2_q        <= sync1_q;
            trig_prev_q    <= sync2_q;
            cnt_q          <= cnt_d;
            pulses_left_q  <= pulses_left_d;
            step_q         <= step_d;
            width_m1_q     <= width_m1_d;
            gap_m1_q       <= gap_m1_d;
            pulses_m1_q    <= pulses_m1_d;
            attempts_m1_q  <= attempts_m1_d;
            holdoff_q      <= holdoff_d;
            timeout_q      <= timeout_d;
            fault_q        <= fault_d;
            attempt_done_q <= attempt_done_d;
            missed_q       <= missed_d;
            sweep_done_q   <= sweep_done_d;
            attempt_idx_q  <= attempt_idx_d;
            cur_delay_q    <= cur_delay_d;
        end
    end

    assign fault_out    = fault_q;
    assign busy         = (state_q != StIdle);
    assign armed        = (state_q == StArm);
    assign attempt_done = attempt_done_q;
    assign missed       = missed_q;
    assign attempt_idx  = attempt_idx_q;
    assign cur_delay    = cur_delay_q;
    assign sweep_done   = sweep_done_q;

endmodule
